// File: rtl/glyph_pkg.sv
// Shared state encoding and default geometry for the scaled glyph renderer.
// Modules import this package; SGR_TRANSPARENT_EN is handled in the top.
package glyph_pkg;

  localparam int GLYPH_W  = 8;
  localparam int GLYPH_H  = 8;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/glyph_block_counter.sv
// Nested sx/sy/col/row counters walking a glyph one scaled block at a time.
// step_px advances within a block; step_bit jumps straight to the next bit.
module glyph_block_counter #(
  parameter int GLYPH_W = glyph_pkg::GLYPH_W,
  parameter int GLYPH_H = glyph_pkg::GLYPH_H,
  parameter int SCALE_W = 3,
  localparam int CW = $clog2(GLYPH_W),
  localparam int RW = $clog2(GLYPH_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               step_px,
  input  logic               step_bit,
  input  logic [SCALE_W-1:0] scale,
  output logic [SCALE_W-1:0] sx,
  output logic [SCALE_W-1:0] sy,
  output logic [CW-1:0]      col,
  output logic [RW-1:0]      row,
  output logic               sx_wrap,
  output logic               sy_wrap,
  output logic               col_wrap,
  output logic               row_wrap
);
  import glyph_pkg::*;

  logic next_bit;

  assign sx_wrap  = (sx == scale - 1'b1);
  assign sy_wrap  = (sy == scale - 1'b1);
  assign col_wrap = (col == CW'(GLYPH_W - 1));
  assign row_wrap = (row == RW'(GLYPH_H - 1));
  assign next_bit = step_bit | (step_px & sx_wrap & sy_wrap);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      sx  <= '0;
      sy  <= '0;
      col <= '0;
      row <= '0;
    end else if (next_bit) begin
      sx  <= '0;
      sy  <= '0;
      col <= col_wrap ? '0 : col + 1'b1;
      if (col_wrap)
        row <= row_wrap ? '0 : row + 1'b1;
    end else if (step_px) begin
      if (sx_wrap) begin
        sx <= '0;
        sy <= sy + 1'b1;
      end else begin
        sx <= sx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scaled_glyph_renderer.sv
// Renders one ROM glyph as scale x scale pixel blocks to a ready/plot sink.
// Define SGR_TRANSPARENT_EN to skip clear bits instead of drawing colour 0.
module scaled_glyph_renderer #(
  parameter int GLYPH_W  = glyph_pkg::GLYPH_W,
  parameter int GLYPH_H  = glyph_pkg::GLYPH_H,
  parameter int SYM_W    = 6,
  parameter int CLR_W    = 3,
  parameter int SCALE_W  = 3,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = glyph_pkg::SCREEN_W,
  parameter int SCREEN_H = glyph_pkg::SCREEN_H,
  localparam int CW = $clog2(GLYPH_W),
  localparam int RW = $clog2(GLYPH_H),
  localparam int AW = SYM_W + CW + RW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [X_W-1:0]     Xin,
  input  logic [Y_W-1:0]     Yin,
  input  logic [CLR_W-1:0]   Clrin,
  input  logic [SCALE_W-1:0] Scalein,
  input  logic [SYM_W-1:0]   Symbol,
  output logic [AW-1:0]      rom_addr,
  input  logic               rom_q,
  output logic [X_W-1:0]     Xsym,
  output logic [Y_W-1:0]     Ysym,
  output logic [CLR_W-1:0]   Clrsym,
  output logic               plot,
  input  logic               ready,
  output logic               busy,
  output logic               done
);
  import glyph_pkg::*;

  localparam logic [X_W:0] XLIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] YLIM = (Y_W+1)'(SCREEN_H);

  state_t state, nxt;

  logic [X_W-1:0]     x_r;
  logic [Y_W-1:0]     y_r;
  logic [CLR_W-1:0]   clr_r;
  logic [SCALE_W-1:0] scale_r;
  logic [SYM_W-1:0]   sym_r;
  logic               bit_r;

  logic [SCALE_W-1:0] sx, sy;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic sx_wrap, sy_wrap, col_wrap, row_wrap;
  logic cnt_clr, step_px, step_bit;
  logic blk_end, last_bit, vis, skip;

  logic [X_W:0] x_full;
  logic [Y_W:0] y_full;

  glyph_block_counter #(
    .GLYPH_W (GLYPH_W),
    .GLYPH_H (GLYPH_H),
    .SCALE_W (SCALE_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .step_px  (step_px),
    .step_bit (step_bit),
    .scale    (scale_r),
    .sx       (sx),
    .sy       (sy),
    .col      (col),
    .row      (row),
    .sx_wrap  (sx_wrap),
    .sy_wrap  (sy_wrap),
    .col_wrap (col_wrap),
    .row_wrap (row_wrap)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      x_r     <= '0;
      y_r     <= '0;
      clr_r   <= '0;
      scale_r <= '0;
      sym_r   <= '0;
      bit_r   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && go) begin
        x_r     <= Xin;
        y_r     <= Yin;
        clr_r   <= Clrin;
        sym_r   <= Symbol;
        scale_r <= (Scalein == '0) ? SCALE_W'(1) : Scalein;
      end
      if (state == S_WAIT)
        bit_r <= rom_q;
    end
  end

  // Unwrapped sums carry one extra bit so off-screen pixels can be detected.
  assign x_full = (X_W+1)'(x_r)
                + (X_W+1)'(col) * (X_W+1)'(scale_r)
                + (X_W+1)'(sx);
  assign y_full = (Y_W+1)'(y_r)
                + (Y_W+1)'(row) * (Y_W+1)'(scale_r)
                + (Y_W+1)'(sy);

  assign vis      = (x_full < XLIM) && (y_full < YLIM);
  assign blk_end  = sx_wrap & sy_wrap;
  assign last_bit = col_wrap & row_wrap;

  assign rom_addr = {sym_r, row, col};
  assign Xsym     = x_full[X_W-1:0];
  assign Ysym     = y_full[Y_W-1:0];
  assign Clrsym   = bit_r ? clr_r : '0;
  assign busy     = (state != S_IDLE);

  always_comb begin
    nxt      = state;
    cnt_clr  = 1'b0;
    step_px  = 1'b0;
    step_bit = 1'b0;
    plot     = 1'b0;
    done     = 1'b0;
    skip     = 1'b0;
`ifdef SGR_TRANSPARENT_EN
    skip     = ~bit_r;
`endif
    unique case (state)
      S_IDLE: begin
        if (go) begin
          cnt_clr = 1'b1;
          nxt     = S_FETCH;
        end
      end
      S_FETCH: nxt = S_WAIT;
      S_WAIT:  nxt = S_EMIT;
      S_EMIT: begin
        if (skip) begin
          step_bit = 1'b1;
          nxt      = last_bit ? S_DONE : S_FETCH;
        end else begin
          plot = vis;
          if (!vis || ready) begin
            step_px = 1'b1;
            if (blk_end)
              nxt = last_bit ? S_DONE : S_FETCH;
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_scaled_glyph_renderer.sv
// Scoreboard bench for scaled_glyph_renderer with a 1-cycle glyph ROM model.
// Expectations follow SGR_TRANSPARENT_EN when the bench is built with it.
module tb_scaled_glyph_renderer;

  localparam int AW = 12;
`ifdef SGR_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } px_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic [7:0]    Xin = '0;
  logic [6:0]    Yin = '0;
  logic [2:0]    Clrin = '0;
  logic [2:0]    Scalein = '0;
  logic [5:0]    Symbol = '0;
  logic [AW-1:0] rom_addr;
  logic          rom_q = 1'b0;
  logic [7:0]    Xsym;
  logic [6:0]    Ysym;
  logic [2:0]    Clrsym;
  logic          plot;
  logic          ready = 1'b1;
  logic          busy;
  logic          done;

  logic rom_mem [0:(1<<AW)-1];
  px_t  exp_q[$];
  px_t  e;
  int   n_assert = 0;
  int   n_fail = 0;
  int   n_plot = 0;

  scaled_glyph_renderer dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .Xin      (Xin),
    .Yin      (Yin),
    .Clrin    (Clrin),
    .Scalein  (Scalein),
    .Symbol   (Symbol),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .Xsym     (Xsym),
    .Ysym     (Ysym),
    .Clrsym   (Clrsym),
    .plot     (plot),
    .ready    (ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  // Scoreboard: a pixel transfers on the edge after a negedge with plot & ready.
  always @(negedge clk) begin
    if (reset && plot) begin
      n_assert++;
      if (Xsym >= 8'd160 || Ysym >= 7'd120) begin
        n_fail++;
        $display("FAIL offscreen: plot at (%0d,%0d), required x<160 y<120",
                 Xsym, Ysym);
      end
      if (ready) begin
        n_plot++;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_pixel: got (%0d,%0d,c%0d), required none",
                   Xsym, Ysym, Clrsym);
        end else begin
          e = exp_q.pop_front();
          if (Xsym !== e.x || Ysym !== e.y || Clrsym !== e.c) begin
            n_fail++;
            $display("FAIL pixel: got (%0d,%0d,c%0d), required (%0d,%0d,c%0d)",
                     Xsym, Ysym, Clrsym, e.x, e.y, e.c);
          end
        end
      end
    end
  end

  task automatic model_push(input logic [7:0] x, input logic [6:0] y,
                            input logic [2:0] c, input logic [2:0] s,
                            input logic [5:0] sym, output int n);
    int sc, xf, yf;
    logic b;
    logic [AW-1:0] a;
    n  = 0;
    sc = (s == 3'd0) ? 1 : int'(s);
    for (int r = 0; r < 8; r++) begin
      for (int cl = 0; cl < 8; cl++) begin
        a = {sym, 3'(r), 3'(cl)};
        b = rom_mem[a];
        if (TRANSP && !b) continue;
        for (int yy = 0; yy < sc; yy++) begin
          for (int xx = 0; xx < sc; xx++) begin
            xf = int'(x) + cl * sc + xx;
            yf = int'(y) + r * sc + yy;
            if (xf < 160 && yf < 120) begin
              exp_q.push_back(px_t'{x: 8'(xf), y: 7'(yf), c: (b ? c : 3'd0)});
              n++;
            end
          end
        end
      end
    end
  endtask

  task automatic start_glyph(input logic [7:0] x, input logic [6:0] y,
                             input logic [2:0] c, input logic [2:0] s,
                             input logic [5:0] sym);
    @(posedge clk);
    #1;
    Xin = x; Yin = y; Clrin = c; Scalein = s; Symbol = sym;
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_glyph(input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic [2:0] s,
                           input logic [5:0] sym, output int n, output bit ok);
    model_push(x, y, c, s, sym, n);
    start_glyph(x, y, c, s, sym);
    wait_done(ok);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert++;
    if ({plot, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: plot/busy/done=%b, required 000",
               {plot, busy, done});
    end
    n_assert++;
    if ({Xsym, Ysym} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_xy: got (%0d,%0d), required (0,0)", Xsym, Ysym);
    end
    n_assert++;
    if (Clrsym !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_clr: got %0d, required 0", Clrsym);
    end
    n_assert++;
    if (rom_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_addr: got %0d, required 0", rom_addr);
    end
    reset = 1'b1;
  endtask

  task automatic check_end(input string nm, input int p0, input int want,
                           input bit ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: done not seen, required done pulse", nm);
    end
    @(negedge clk);
    n_assert++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_width: done=%b a cycle later, required 0", nm, done);
    end
    n_assert++;
    if (n_plot - p0 != want) begin
      n_fail++;
      $display("FAIL %s_count: got %0d plots, required %0d", nm, n_plot - p0, want);
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing: %0d pixels outstanding, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_all_ones;
    int p0, n;
    bit ok;
    p0 = n_plot;
    run_glyph(8'd10, 7'd20, 3'd5, 3'd1, 6'd0, n, ok);
    check_end("all_ones", p0, 64, ok);
  endtask

  task automatic test_single_bit;
    int p0, n;
    bit ok;
    p0 = n_plot;
    run_glyph(8'd0, 7'd0, 3'd6, 3'd2, 6'd1, n, ok);
    check_end("single_bit", p0, TRANSP ? 4 : 256, ok);
  endtask

  task automatic test_clip;
    int p0, n;
    bit ok;
    p0 = n_plot;
    run_glyph(8'd156, 7'd0, 3'd3, 3'd1, 6'd0, n, ok);
    check_end("clip", p0, 32, ok);
  endtask

  task automatic test_backpressure;
    int p0, n;
    bit ok, seen;
    logic [7:0] hx;
    logic [6:0] hy;
    logic [2:0] hc;
    p0 = n_plot;
    seen = 1'b0;
    fork
      run_glyph(8'd20, 7'd30, 3'd7, 3'd2, 6'd2, n, ok);
      begin
        repeat (40) @(posedge clk);
        for (int i = 0; i < 2000 && !seen; i++) begin
          @(posedge clk);
          #1;
          if (plot) seen = 1'b1;
        end
        n_assert++;
        if (!seen) begin
          n_fail++;
          $display("FAIL stall_start: plot never seen, required plot=1");
        end else begin
          ready = 1'b0;
          hx = Xsym; hy = Ysym; hc = Clrsym;
          repeat (5) begin
            @(negedge clk);
            n_assert++;
            if ({plot, Xsym, Ysym, Clrsym} !== {1'b1, hx, hy, hc}) begin
              n_fail++;
              $display("FAIL stall_hold: got p%b (%0d,%0d,c%0d), required p1 (%0d,%0d,c%0d)",
                       plot, Xsym, Ysym, Clrsym, hx, hy, hc);
            end
          end
          @(posedge clk);
          #1 ready = 1'b1;
        end
      end
    join
    check_end("stall", p0, n, ok);
  endtask

  task automatic test_reset_mid;
    int p0, n;
    bit ok, seen;
    model_push(8'd10, 7'd20, 3'd2, 3'd1, 6'd0, n);
    start_glyph(8'd10, 7'd20, 3'd2, 3'd1, 6'd0);
    seen = 1'b0;
    repeat (20) @(posedge clk);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (plot) seen = 1'b1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_assert++;
    if ({seen, plot, busy, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL mid_reset: seen/plot/busy/done=%b, required 1000",
               {seen, plot, busy, done});
    end
    n_assert++;
    if ({Xsym, Ysym, rom_addr} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_out: got (%0d,%0d) addr %0d, required zeros",
               Xsym, Ysym, rom_addr);
    end
    exp_q.delete();
    reset = 1'b1;
    p0 = n_plot;
    run_glyph(8'd10, 7'd20, 3'd2, 3'd1, 6'd0, n, ok);
    check_end("after_reset", p0, 64, ok);
  endtask

  task automatic test_scale0_busy_go;
    int p0, n;
    bit ok;
    p0 = n_plot;
    fork
      run_glyph(8'd30, 7'd40, 3'd4, 3'd0, 6'd2, n, ok);
      begin
        repeat (30) @(posedge clk);
        #1;
        Xin = 8'd99; Yin = 7'd99; Symbol = 6'd1; Scalein = 3'd3;
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
      end
    join
    check_end("scale0", p0, n, ok);
  endtask

  task automatic test_back_to_back;
    int p0, n1, n2;
    bit ok1, ok2;
    p0 = n_plot;
    model_push(8'd0, 7'd50, 3'd1, 3'd1, 6'd0, n1);
    start_glyph(8'd0, 7'd50, 3'd1, 3'd1, 6'd0);
    wait_done(ok1);
    model_push(8'd100, 7'd60, 3'd2, 3'd1, 6'd2, n2);
    Xin = 8'd100; Yin = 7'd60; Clrin = 3'd2; Scalein = 3'd1; Symbol = 6'd2;
    go = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 go = 1'b0;
    n_assert++;
    if ({ok1, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_start: ok/busy=%b, required 11", {ok1, busy});
    end
    wait_done(ok2);
    check_end("b2b", p0, n1 + n2, ok2);
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) rom_mem[a] = 1'b0;
    for (int i = 0; i < 64; i++) rom_mem[i] = 1'b1;
    rom_mem[64 + 8 + 2] = 1'b1;
    for (int i = 0; i < 64; i++) rom_mem[128 + i] = ((i * 7) % 3) == 0;

    test_reset;
    test_all_ones;
    test_single_bit;
    test_clip;
    test_backpressure;
    test_reset_mid;
    test_scale0_busy_go;
    test_back_to_back;

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
